// File: rtl/svpwm_gen_pkg.sv
// Shared parameters and types for the svpwm_gen space-vector PWM slice.
// Build option SVPWM_DEADTIME_EN enables the per-phase dead-time inserter.
package tdef_prm;
  localparam int NPH_D = 3;
  localparam int WIDTH_D = 18;
  localparam int PERIOD_D = 1000;
  localparam int DT_D = 10;
endpackage

package tdef_pkg;
  import tdef_prm::*;
  localparam int CW_D = $clog2(PERIOD_D + 1);

  typedef enum logic {UP, DOWN} svpwm_dir_t;
  typedef logic [CW_D-1:0] svpwm_duty_t;
  typedef logic signed [NPH_D-1:0][WIDTH_D-1:0] svpwm_volt_t;

  typedef struct packed {
    logic clk;
    logic rstn;
    logic ce;
  } clock_t;

  typedef enum logic [1:0] {
    OFF_DEAD,
    H_ON,
    L_ON
  } dt_state_t;
endpackage

// File: rtl/svpwm_gen_dt.sv
// Per-phase dead-time inserter for svpwm_gen (used with SVPWM_DEADTIME_EN).
// A side turns on only after raw has been stable DT cycles with both sides off.
module svpwm_dt
  import tdef_pkg::*;
#(
  parameter int DT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic en,
  output logic h,
  output logic l
);
  localparam int TW = $clog2(DT + 1);

  dt_state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic raw_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF_DEAD;
      cnt <= '0;
      raw_d <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      raw_d <= raw;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (!en) begin
      state_n = OFF_DEAD;
      cnt_n = '0;
    end else begin
      unique case (state)
        H_ON: begin
          if (!raw) begin
            state_n = OFF_DEAD;
            cnt_n = '0;
          end
        end
        L_ON: begin
          if (raw) begin
            state_n = OFF_DEAD;
            cnt_n = '0;
          end
        end
        default: begin
          // a change during the dead gap restarts it
          if (raw != raw_d) cnt_n = '0;
          else if (cnt == TW'(DT - 1)) state_n = raw ? H_ON : L_ON;
          else cnt_n = cnt + 1'b1;
        end
      endcase
    end
  end

  assign h = en & (state == H_ON);
  assign l = en & (state == L_ON);
endmodule

// File: rtl/svpwm_gen.sv
// N-phase SVPWM: min/max zero-sequence, duty scaling, double-buffered duties.
// Build option SVPWM_DEADTIME_EN adds a dead-time inserter per phase.
module svpwm_gen
  import tdef_pkg::*;
  import tdef_prm::*;
#(
  parameter int NPH = NPH_D,
  parameter int WIDTH = WIDTH_D,
  parameter int PERIOD = PERIOD_D,
  parameter int CW = $clog2(PERIOD + 1),
  parameter int UPDATE_MODE = 0,
  parameter int DT = DT_D
) (
  input  clock_t                          clock,
  input  logic                            en,
  input  logic signed [NPH-1:0][WIDTH-1:0] voltage_data,
  input  logic                            voltage_val,
  output logic [NPH-1:0]                  pwm_h,
  output logic [NPH-1:0]                  pwm_l,
  output logic                            sync,
  output logic                            ovr
);
  localparam int SW = WIDTH + 1;
  localparam int UW = WIDTH + 2;
  localparam int PW = WIDTH + 1 + CW;
  localparam logic [UW-1:0] HALF =
    {{(UW-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [UW-1:0] FULL = {2'b01, {WIDTH{1'b0}}};

  logic clk, rst_n, unused_ce;
  assign clk = clock.clk;
  assign rst_n = clock.rstn;
  assign unused_ce = clock.ce;

  logic signed [WIDTH-1:0] vmax, vmin, max1, min1;
  logic signed [SW-1:0] sum1, off1, off2;
  logic [NPH-1:0][WIDTH-1:0] v1, v2;
  logic [NPH-1:0][UW-1:0] us;
  logic [NPH-1:0][WIDTH:0] uc, u3;
  logic [PW-1:0] prod;
  logic [NPH-1:0][CW-1:0] duty4, shadow, active;
  logic val1, val2, val3, shadow_full;

  always_comb begin
    vmax = $signed(voltage_data[0]);
    vmin = $signed(voltage_data[0]);
    for (int i = 1; i < NPH; i++) begin
      if ($signed(voltage_data[i]) > vmax) vmax = $signed(voltage_data[i]);
      if ($signed(voltage_data[i]) < vmin) vmin = $signed(voltage_data[i]);
    end
  end

  assign sum1 = SW'(max1) + SW'(min1);
  assign off1 = -(sum1 >>> 1);

  always_comb begin
    us = '0;
    uc = '0;
    for (int i = 0; i < NPH; i++) begin
      us[i] = UW'($signed(v2[i])) + UW'(off2) + HALF;
      if (us[i][UW-1]) uc[i] = '0;
      else if (us[i] > FULL) uc[i] = FULL[WIDTH:0];
      else uc[i] = us[i][WIDTH:0];
    end
  end

  always_comb begin
    prod = '0;
    duty4 = '0;
    for (int i = 0; i < NPH; i++) begin
      prod = PW'(u3[i]) * PW'(PERIOD);
      duty4[i] = CW'(prod >> WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {val1, val2, val3} <= '0;
      {max1, min1, off2} <= '0;
      {v1, v2, u3} <= '0;
    end else begin
      val1 <= voltage_val;
      val2 <= val1;
      val3 <= val2;
      if (voltage_val) begin
        v1 <= voltage_data;
        max1 <= vmax;
        min1 <= vmin;
      end
      if (val1) begin
        v2 <= v1;
        off2 <= off1;
      end
      if (val2) u3 <= uc;
    end
  end

  svpwm_dir_t dir;
  logic [CW-1:0] cnt;
  logic peak, valley, evt, load, valley_q, armed, gate;
  logic [NPH-1:0] raw_q;

  assign peak = en & (dir == UP) & (cnt == CW'(PERIOD - 1));
  assign valley = en & (dir == DOWN) & (cnt == '0);
  assign evt = valley | ((UPDATE_MODE == 1) & peak);
  assign load = evt & shadow_full;
  assign gate = en & armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= UP;
      cnt <= '0;
    end else if (!en) begin
      dir <= UP;
      cnt <= '0;
    end else begin
      unique case (dir)
        UP: if (peak) dir <= DOWN; else cnt <= cnt + 1'b1;
        DOWN: if (valley) dir <= UP; else cnt <= cnt - 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      shadow_full <= 1'b0;
      {sync, ovr, valley_q, armed} <= '0;
      raw_q <= '0;
    end else begin
      // a load and a write together: load takes the old shadow
      if (load) active <= shadow;
      if (val3) shadow <= duty4;
      shadow_full <= val3 | (shadow_full & ~load);
      ovr <= val3 & shadow_full & ~load;
      sync <= evt;
      valley_q <= valley;
      armed <= en & (armed | valley_q);
      for (int i = 0; i < NPH; i++) raw_q[i] <= cnt < active[i];
    end
  end

`ifdef SVPWM_DEADTIME_EN
  for (genvar g = 0; g < NPH; g++) begin : g_dt
    svpwm_dt #(.DT(DT)) u_dt (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_q[g]),
      .en   (gate),
      .h    (pwm_h[g]),
      .l    (pwm_l[g])
    );
  end
`else
  logic [31:0] unused_dt;
  assign unused_dt = 32'(DT);
  assign pwm_h = gate ? raw_q : '0;
  assign pwm_l = gate ? ~raw_q : '0;
`endif
endmodule

// File: tb/tb_svpwm_gen.sv
// Scoreboard bench for svpwm_gen: per carrier window, checks on-time,
// centring, complement, overrun pulses and window length against vectors.
module tb_svpwm_gen;
  import tdef_pkg::*;

  localparam int NPH = 3;
  localparam int WIDTH = 18;
  localparam int PERIOD = 1000;
  localparam int LIM = 2 * PERIOD + 500;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  clock_t clock;
  logic en, voltage_val, sync, ovr;
  logic signed [NPH-1:0][WIDTH-1:0] voltage_data;
  logic [NPH-1:0] pwm_h, pwm_l;

  assign clock = {clk, rstn, 1'b1};

  svpwm_gen #(
    .NPH(NPH),
    .WIDTH(WIDTH),
    .PERIOD(PERIOD)
  ) dut (
    .clock       (clock),
    .en          (en),
    .voltage_data(voltage_data),
    .voltage_val (voltage_val),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .sync        (sync),
    .ovr         (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit off;
    bit chk_len;
    int novr;
    int d[NPH];
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(int id, bit off, bit cl, int nv,
                              int a, int b, int c);
    exp_t e;
    e.id = id;
    e.off = off;
    e.chk_len = cl;
    e.novr = nv;
    e.d[0] = a;
    e.d[1] = b;
    e.d[2] = c;
    return e;
  endfunction

  // monitor: accumulate per window, compare at each sync
  int hc[NPH], lc[NPH], hf[NPH];
  int len = 0, ovc = 0, ovl = 0;

  initial begin
    exp_t e;
    for (int i = 0; i < NPH; i++) begin
      hc[i] = 0;
      lc[i] = 0;
      hf[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      len++;
      for (int i = 0; i < NPH; i++) begin
        hc[i] += int'(pwm_h[i]);
        lc[i] += int'(pwm_l[i]);
        if (len <= PERIOD) hf[i] += int'(pwm_h[i]);
      end
      if (|(pwm_h & pwm_l)) ovl++;
      if (ovr) ovc++;
      if (sync) begin
        if (q.size() == 0) begin
          check("sb_empty", 0, 1);
        end else begin
          e = q.pop_front();
          for (int i = 0; i < NPH; i++) begin
            check($sformatf("w%0d_h%0d", e.id, i), hc[i],
                  e.off ? 0 : 2 * e.d[i]);
            check($sformatf("w%0d_l%0d", e.id, i), lc[i],
                  e.off ? 0 : 2 * PERIOD - 2 * e.d[i]);
            check($sformatf("w%0d_half%0d", e.id, i), hf[i],
                  e.off ? 0 : e.d[i]);
          end
          check($sformatf("w%0d_ovr", e.id), ovc, e.novr);
          check($sformatf("w%0d_overlap", e.id), ovl, 0);
          if (e.chk_len)
            check($sformatf("w%0d_len", e.id), len, 2 * PERIOD);
        end
        len = 0;
        ovc = 0;
        ovl = 0;
        for (int i = 0; i < NPH; i++) begin
          hc[i] = 0;
          lc[i] = 0;
          hf[i] = 0;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(int a, int b, int c);
    voltage_data[0] = WIDTH'(a);
    voltage_data[1] = WIDTH'(b);
    voltage_data[2] = WIDTH'(c);
    voltage_val = 1'b1;
    @(negedge clk);
    voltage_val = 1'b0;
  endtask

  task automatic wait_sync(string name);
    int n;
    @(negedge clk);
    n = 1;
    while (!sync && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(sync), 1);
  endtask

  initial begin
    en = 1'b0;
    voltage_val = 1'b0;
    voltage_data = '0;
    rstn = 1'b0;
    tick(3);
    check("rst_h", int'(pwm_h), 0);
    check("rst_l", int'(pwm_l), 0);
    check("rst_sync", int'(sync), 0);
    check("rst_ovr", int'(ovr), 0);
    rstn = 1'b1;
    tick(2);

    // zero input while disabled: duty 500 waits in the shadow
    strobe(0, 0, 0);
    tick(10);
    q.push_back(mk(1, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(2, 0, 1, 0, 500, 500, 500));
    en = 1'b1;
    wait_sync("sync1");

    tick(500);
    strobe(65536, -32768, -32768);
    q.push_back(mk(3, 0, 1, 0, 687, 312, 312));
    wait_sync("sync2");

    tick(300);
    strobe(131071, -131072, 0);
    q.push_back(mk(4, 0, 1, 1, 1000, 0, 500));
    wait_sync("sync3");

    // overrun: second strobe 10 cycles later wins
    tick(300);
    strobe(131071, -131072, 0);
    tick(9);
    strobe(65536, -32768, -32768);
    q.push_back(mk(5, 0, 1, 0, 687, 312, 312));
    wait_sync("sync4");

    wait_sync("sync5");
    q.push_back(mk(6, 1, 0, 0, 0, 0, 0));
    q.push_back(mk(7, 0, 1, 0, 687, 312, 312));
    en = 1'b0;
    #1;
    check("dis_h", int'(pwm_h), 0);
    check("dis_l", int'(pwm_l), 0);
    tick(200);
    check("dis_h_late", int'(pwm_h), 0);
    check("dis_l_late", int'(pwm_l), 0);
    check("dis_sync", int'(sync), 0);
    en = 1'b1;
    wait_sync("sync6");
    wait_sync("sync7");

    tick(700);
    check("pre_rst_l1", int'(pwm_l[1]), 1);
    rstn = 1'b0;
    #1;
    check("async_rst_h", int'(pwm_h), 0);
    check("async_rst_l", int'(pwm_l), 0);
    tick(2);
    check("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
